// File: rtl/fifo_rd_stream.sv
// Read-side drain engine: pops an async FIFO read port into a 2-entry valid/ready buffer with burst framing.
// Optional statistics counters are built only when FIFO_RD_STATS_EN is defined.
module fifo_rd_stream #(
    parameter int DATA_WIDTH = 3,
    parameter int BURST_LEN  = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  r_clk,
    input  logic                  r_rst,
    input  logic                  enable,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_rdata,
    output logic                  fifo_ren,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic [CNT_WIDTH-1:0]  word_cnt,
    output logic [CNT_WIDTH-1:0]  starve_cnt
);

    localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [BEAT_W-1:0] BEAT_MAX = BEAT_W'(BURST_LEN - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                state_reg;
    logic [1:0]            occ_reg;
    logic [DATA_WIDTH-1:0] head_reg;
    logic [DATA_WIDTH-1:0] tail_reg;
    logic [BEAT_W-1:0]     pop_beat_reg;
    logic [BEAT_W-1:0]     out_beat_reg;

    logic allow;
    logic pop;
    logic accept;

    // DRAIN keeps popping only while a burst is partially consumed, so bursts are never split.
    always_comb begin
        allow = 1'b0;
        case (state_reg)
            RUN:     allow = 1'b1;
            DRAIN:   allow = (pop_beat_reg != '0);
            default: allow = 1'b0;
        endcase
    end

    assign pop      = ~fifo_empty & (occ_reg != 2'd2) & allow;
    assign fifo_ren = pop;
    assign m_valid  = (occ_reg != 2'd0);
    assign accept   = m_valid & m_ready;
    assign m_data   = head_reg;
    assign m_last   = m_valid & (out_beat_reg == BEAT_MAX);

    always_ff @(posedge r_clk or posedge r_rst) begin
        if (r_rst) begin
            state_reg <= IDLE;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (enable) state_reg <= RUN;
                end
                RUN: begin
                    if (!enable) state_reg <= DRAIN;
                end
                DRAIN: begin
                    if (enable)
                        state_reg <= RUN;
                    else if ((pop_beat_reg == '0) && (occ_reg == 2'd0))
                        state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Head is always the output word; tail only ever holds the second-oldest word.
    always_ff @(posedge r_clk or posedge r_rst) begin
        if (r_rst) begin
            occ_reg  <= 2'd0;
            head_reg <= '0;
            tail_reg <= '0;
        end else begin
            case (occ_reg)
                2'd0: begin
                    if (pop) begin
                        head_reg <= fifo_rdata;
                        occ_reg  <= 2'd1;
                    end
                end
                2'd1: begin
                    if (pop && accept) begin
                        head_reg <= fifo_rdata;
                    end else if (pop) begin
                        tail_reg <= fifo_rdata;
                        occ_reg  <= 2'd2;
                    end else if (accept) begin
                        occ_reg  <= 2'd0;
                    end
                end
                default: begin
                    if (accept) begin
                        head_reg <= tail_reg;
                        occ_reg  <= 2'd1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge r_clk or posedge r_rst) begin
        if (r_rst) begin
            pop_beat_reg <= '0;
            out_beat_reg <= '0;
        end else begin
            if (pop)
                pop_beat_reg <= (pop_beat_reg == BEAT_MAX) ? '0 : pop_beat_reg + BEAT_W'(1);
            if (accept)
                out_beat_reg <= (out_beat_reg == BEAT_MAX) ? '0 : out_beat_reg + BEAT_W'(1);
        end
    end

`ifdef FIFO_RD_STATS_EN
    logic [CNT_WIDTH-1:0] word_cnt_reg;
    logic [CNT_WIDTH-1:0] starve_cnt_reg;
    logic                 starve;

    // Starvation: downstream is ready and nothing is buffered or available upstream.
    assign starve = (state_reg != IDLE) & m_ready & (occ_reg == 2'd0) & fifo_empty;

    always_ff @(posedge r_clk or posedge r_rst) begin
        if (r_rst) begin
            word_cnt_reg   <= '0;
            starve_cnt_reg <= '0;
        end else begin
            if (accept && (word_cnt_reg != '1))
                word_cnt_reg <= word_cnt_reg + CNT_WIDTH'(1);
            if (starve && (starve_cnt_reg != '1))
                starve_cnt_reg <= starve_cnt_reg + CNT_WIDTH'(1);
        end
    end

    assign word_cnt   = word_cnt_reg;
    assign starve_cnt = starve_cnt_reg;
`else
    assign word_cnt   = '0;
    assign starve_cnt = '0;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream: a queue models the FIFO read port, accepted words are logged for checking.
module tb_fifo_rd_stream;

    logic        r_clk;
    logic        r_rst;
    logic        enable;
    logic        fifo_empty;
    logic [2:0]  fifo_rdata;
    logic        fifo_ren;
    logic        m_valid;
    logic        m_ready;
    logic [2:0]  m_data;
    logic        m_last;
    logic [15:0] word_cnt;
    logic [15:0] starve_cnt;

    int n_cmp = 0;
    int n_err = 0;
    int pops  = 0;

    logic [2:0] q[$];
    logic [3:0] rx[$];

    logic       ren_neg  = 1'b0;
    logic       acc_neg  = 1'b0;
    logic [2:0] data_neg = '0;
    logic       last_neg = 1'b0;

    fifo_rd_stream #(
        .DATA_WIDTH(3),
        .BURST_LEN (8),
        .CNT_WIDTH (16)
    ) dut (
        .r_clk     (r_clk),
        .r_rst     (r_rst),
        .enable    (enable),
        .fifo_empty(fifo_empty),
        .fifo_rdata(fifo_rdata),
        .fifo_ren  (fifo_ren),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_last    (m_last),
        .word_cnt  (word_cnt),
        .starve_cnt(starve_cnt)
    );

    initial r_clk = 1'b0;
    always #5 r_clk = ~r_clk;

    // Handshake values are stable mid-cycle; capture them for the next rising edge.
    always @(negedge r_clk) begin
        ren_neg  = fifo_ren;
        acc_neg  = m_valid && m_ready;
        data_neg = m_data;
        last_neg = m_last;
        if (!r_rst && fifo_empty) begin
            n_cmp++;
            if (fifo_ren !== 1'b0) begin
                n_err++;
                $display("FAIL ren_while_empty: fifo_ren=%b required 0 at %0t", fifo_ren, $time);
            end
        end
    end

    task automatic refresh();
        fifo_empty = (q.size() == 0);
        fifo_rdata = fifo_empty ? 3'd0 : q[0];
    endtask

    task automatic tick();
        @(posedge r_clk);
        #1;
        if (ren_neg) begin
            pops++;
            if (q.size() > 0) void'(q.pop_front());
        end
        if (acc_neg) rx.push_back({last_neg, data_neg});
        refresh();
    endtask

    task automatic do_reset();
        r_rst   = 1'b1;
        enable  = 1'b0;
        m_ready = 1'b0;
        q.delete();
        refresh();
        repeat (2) @(posedge r_clk);
        #1;
        r_rst = 1'b0;
        rx.delete();
        pops = 0;
    endtask

    task automatic test_reset();
        r_rst   = 1'b1;
        enable  = 1'b1;
        m_ready = 1'b1;
        q.delete();
        q.push_back(3'd5); q.push_back(3'd6); q.push_back(3'd7); q.push_back(3'd1);
        refresh();
        repeat (3) tick();
        n_cmp++;
        if ({m_valid, m_data, m_last, fifo_ren} !== 6'b0) begin
            n_err++;
            $display("FAIL reset_outputs: valid/data/last/ren=%b required 000000", {m_valid, m_data, m_last, fifo_ren});
        end
        n_cmp++;
        if ({word_cnt, starve_cnt} !== 32'd0) begin
            n_err++;
            $display("FAIL reset_counters: word=%0d starve=%0d required 0 0", word_cnt, starve_cnt);
        end
        enable = 1'b0;
        r_rst  = 1'b0;
        repeat (3) tick();
        n_cmp++;
        if (q.size() != 4 || q[0] !== 3'd5 || fifo_ren !== 1'b0 || m_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_fifo_untouched: size=%0d ren=%b valid=%b required 4 0 0", q.size(), fifo_ren, m_valid);
        end

        // Reset in the middle of a run discards buffered words but not FIFO contents.
        do_reset();
        for (int i = 0; i < 8; i++) q.push_back(3'(i));
        refresh();
        enable = 1'b1;
        repeat (3) tick();
        n_cmp++;
        if (q.size() != 6 || m_valid !== 1'b1 || fifo_ren !== 1'b0) begin
            n_err++;
            $display("FAIL midreset_fill: size=%0d valid=%b ren=%b required 6 1 0", q.size(), m_valid, fifo_ren);
        end
        r_rst = 1'b1;
        #1;
        n_cmp++;
        if ({m_valid, m_data, m_last, fifo_ren} !== 6'b0) begin
            n_err++;
            $display("FAIL midreset_outputs: valid/data/last/ren=%b required 000000", {m_valid, m_data, m_last, fifo_ren});
        end
        tick();
        n_cmp++;
        if (q.size() != 6) begin
            n_err++;
            $display("FAIL midreset_fifo: size=%0d required 6", q.size());
        end
        $display("test_reset done: compared=%0d mismatched=%0d", n_cmp, n_err);
    endtask

    task automatic test_streaming();
        logic [4:0] exp;
        do_reset();
        for (int i = 0; i < 16; i++) q.push_back(3'(i));
        refresh();
        enable  = 1'b1;
        m_ready = 1'b1;
        tick();
        n_cmp++;
        if (fifo_ren !== 1'b1 || m_valid !== 1'b0) begin
            n_err++;
            $display("FAIL stream_start: ren=%b valid=%b required 1 0", fifo_ren, m_valid);
        end
        for (int i = 0; i < 16; i++) begin
            tick();
            exp = {1'b1, (i % 8) == 7, 3'(i)};
            n_cmp++;
            if ({m_valid, m_last, m_data} !== exp) begin
                n_err++;
                $display("FAIL stream_word%0d: valid/last/data=%b required %b", i, {m_valid, m_last, m_data}, exp);
            end
        end
        enable = 1'b0;
        repeat (3) tick();
        n_cmp++;
        if (rx.size() != 16 || m_valid !== 1'b0 || q.size() != 0 || fifo_ren !== 1'b0) begin
            n_err++;
            $display("FAIL stream_end: accepted=%0d valid=%b left=%0d required 16 0 0", rx.size(), m_valid, q.size());
        end
        $display("test_streaming done: accepted=%0d", rx.size());
    endtask

    task automatic test_backpressure();
        logic [3:0] exp;
        do_reset();
        for (int i = 0; i < 16; i++) q.push_back(3'(i));
        refresh();
        enable  = 1'b1;
        m_ready = 1'b1;
        repeat (4) tick();
        m_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            n_cmp++;
            if ({m_valid, m_data, fifo_ren} !== 5'b1_010_0) begin
                n_err++;
                $display("FAIL bp_stall%0d: valid/data/ren=%b required 10100", c, {m_valid, m_data, fifo_ren});
            end
        end
        n_cmp++;
        if (q.size() != 12) begin
            n_err++;
            $display("FAIL bp_buffered: fifo left=%0d required 12", q.size());
        end
        m_ready = 1'b1;
        for (int c = 0; c < 40 && rx.size() < 16; c++) tick();
        n_cmp++;
        if (rx.size() != 16) begin
            n_err++;
            $display("FAIL bp_count: accepted=%0d required 16", rx.size());
        end
        for (int i = 0; i < 16 && i < rx.size(); i++) begin
            exp = {(i % 8) == 7, 3'(i)};
            n_cmp++;
            if (rx[i] !== exp) begin
                n_err++;
                $display("FAIL bp_word%0d: last/data=%b required %b", i, rx[i], exp);
            end
        end
        enable = 1'b0;
        repeat (3) tick();
        $display("test_backpressure done: accepted=%0d", rx.size());
    endtask

    task automatic test_burst_stop();
        logic [3:0] exp;
        do_reset();
        for (int i = 0; i < 12; i++) q.push_back(3'(i + 3));
        refresh();
        enable  = 1'b1;
        m_ready = 1'b1;
        for (int c = 0; c < 20 && pops < 3; c++) tick();
        enable = 1'b0;
        repeat (20) tick();
        n_cmp++;
        if (rx.size() != 8) begin
            n_err++;
            $display("FAIL stop_count: accepted=%0d required 8", rx.size());
        end
        for (int i = 0; i < 8 && i < rx.size(); i++) begin
            exp = {i == 7, 3'(i + 3)};
            n_cmp++;
            if (rx[i] !== exp) begin
                n_err++;
                $display("FAIL stop_word%0d: last/data=%b required %b", i, rx[i], exp);
            end
        end
        n_cmp++;
        if (q.size() != 4 || q[0] !== 3'd3 || fifo_ren !== 1'b0 || m_valid !== 1'b0) begin
            n_err++;
            $display("FAIL stop_idle: left=%0d ren=%b valid=%b required 4 0 0", q.size(), fifo_ren, m_valid);
        end
        $display("test_burst_stop done: accepted=%0d left=%0d", rx.size(), q.size());
    endtask

    task automatic test_counters();
        logic [15:0] exp_word;
        logic [15:0] exp_starve;
`ifdef FIFO_RD_STATS_EN
        exp_word   = 16'd3;
        exp_starve = 16'd4;
`else
        exp_word   = 16'd0;
        exp_starve = 16'd0;
`endif
        do_reset();
        enable  = 1'b1;
        m_ready = 1'b1;
        tick();
        repeat (4) tick();
        q.push_back(3'd2); q.push_back(3'd4); q.push_back(3'd6);
        refresh();
        repeat (4) tick();
        n_cmp++;
        if (word_cnt !== exp_word) begin
            n_err++;
            $display("FAIL cnt_word: word_cnt=%0d required %0d", word_cnt, exp_word);
        end
        n_cmp++;
        if (starve_cnt !== exp_starve) begin
            n_err++;
            $display("FAIL cnt_starve: starve_cnt=%0d required %0d", starve_cnt, exp_starve);
        end
        enable = 1'b0;
        $display("test_counters done: word_cnt=%0d starve_cnt=%0d", word_cnt, starve_cnt);
    endtask

    initial begin
        r_rst      = 1'b1;
        enable     = 1'b0;
        m_ready    = 1'b0;
        fifo_empty = 1'b1;
        fifo_rdata = 3'd0;
        test_reset();
        test_streaming();
        test_backpressure();
        test_burst_stop();
        test_counters();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fifo_rd_stream.md
# fifo_rd_stream

Read-side drain engine for the asynchronous FIFO. It sits entirely in the read clock domain and pops the FIFO's read port (empty / read enable / combinational head data). It re-presents the words as a valid/ready stream with burst framing (`m_last` every `BURST_LEN` words) and a 2-entry output buffer that sustains one word per cycle. A run/drain control stops consumption only on burst boundaries.

## Interface
Parameters:
- `DATA_WIDTH`, 3 — word width; must match the FIFO.
- `BURST_LEN`, 8 — words per burst, ≥1; `m_last` marks word `BURST_LEN-1`.
- `CNT_WIDTH`, 16 — width of the statistics counters.

Ports:
- `r_clk`  in  1 — read-domain clock; all state on its rising edge.
- `r_rst`  in  1 — asynchronous, active-high reset.
- `enable`  in  1 — run request; sampled each cycle.
- `fifo_empty`  in  1 — FIFO empty flag; head data is valid when low.
- `fifo_rdata`  in  `DATA_WIDTH` — FIFO head word; combinational.
- `fifo_ren`  out  1 — FIFO pop; combinational, never high while `fifo_empty`=1.
- `m_valid`  out  1 — output word valid.
- `m_ready`  in  1 — downstream accept.
- `m_data`  out  `DATA_WIDTH` — output word.
- `m_last`  out  1 — final word of a burst; qualified by `m_valid`.
- `word_cnt`  out  `CNT_WIDTH` — accepted output words; saturating.
- `starve_cnt`  out  `CNT_WIDTH` — starvation cycles; saturating.

## Operation
- **Buffer.** 2-entry FIFO (head/tail registers), occupancy `occ` 0..2. Output is always the head: `m_valid = (occ != 0)`.
- **Pop.** `pop = fifo_ren = ~fifo_empty & (occ < 2) & allow`.
  - `allow` = 1 in RUN.
  - In DRAIN, `allow` = `(pop_beat != 0)`.
  - In IDLE, `allow` = 0.
  - The popped word (`fifo_rdata`) is written into the buffer at that edge.
- **Occupancy.** `occ_next = occ + pop - (m_valid & m_ready)`. Simultaneous pop and accept at `occ`=1 keeps `occ`=1 and shifts the new word into head.
- **`pop_beat`.** Counts pops 0..`BURST_LEN`-1 and wraps to 0 after the `BURST_LEN`-th pop.
- **`out_beat`.** Counts accepted words. `m_last = m_valid & (out_beat == BURST_LEN-1)`. Wraps to 0 on the accept of the last word.
- **FSM** (states IDLE, RUN, DRAIN):
  - IDLE → RUN when `enable`=1.
  - RUN → DRAIN when `enable`=0.
  - DRAIN → RUN when `enable`=1.
  - DRAIN → IDLE when `pop_beat`=0 and `occ`=0.
  - A burst is never split: once its first word is popped, all `BURST_LEN` words are popped and delivered.
- **Stall.** `m_data` and `m_last` hold stable while `m_valid & ~m_ready`.
- **Reset.** `r_rst` at any time clears the buffer (buffered words are discarded). Unpopped FIFO entries stay in the FIFO.

## Timing
- Reset values:
  - `m_valid`=0, `m_data`=0, `m_last`=0.
  - `fifo_ren`=0 (state IDLE).
  - `word_cnt`=0, `starve_cnt`=0.
  - `occ`=0, `pop_beat`=0, `out_beat`=0.
- Latency: `fifo_ren` high in cycle N gives `m_valid`=1 with that word in cycle N+1.
- Throughput: 1 word/cycle with `m_ready` held high and the FIFO non-empty.
- `enable` is first effective the cycle after it is sampled high: IDLE→RUN takes one edge, and `fifo_ren` can go high in the following cycle.
- Backpressure: with `m_ready`=0 at most 2 further words are popped, then `fifo_ren`=0 until an accept.

## Configuration
- `FIFO_RD_STATS_EN` defined:
  - `word_cnt` increments on each `m_valid & m_ready`.
  - `starve_cnt` increments each cycle the FSM is RUN or DRAIN with `m_ready`=1, `occ`=0 and `fifo_empty`=1.
  - Both saturate at all-ones.
- Not defined: no counter logic is built; `word_cnt` and `starve_cnt` are tied to 0. Ports are unchanged.

## Test plan
- **Reset.** Assert `r_rst` with the FIFO non-empty. Required: all outputs at reset values, `fifo_ren`=0, and after release the FIFO contents are unchanged.
- **Streaming.** `enable`=1, `m_ready`=1, FIFO preloaded with 16 words 0..7,0..7 (`DATA_WIDTH`=3). Required:
  - 16 consecutive `m_valid` cycles starting one cycle after the first `fifo_ren`.
  - Data in order.
  - `m_last` on words 8 and 16.
- **Backpressure.** `m_ready`=0 for 5 cycles mid-stream. Required: exactly 2 words buffered, `fifo_ren`=0 thereafter, `m_data` stable; no loss or duplication after `m_ready`=1.
- **Burst-aligned stop.** Drop `enable` after the 3rd pop (`BURST_LEN`=8). Required: words 4..8 still popped and delivered, `m_last` on word 8, then IDLE with `fifo_ren`=0 and the remaining FIFO words untouched.
- **Counters** (with `FIFO_RD_STATS_EN`). `enable`=1, `m_ready`=1, FIFO empty for 4 cycles, then 3 words. Required: `starve_cnt`=4, `word_cnt`=3.
- **Counters** (without `FIFO_RD_STATS_EN`). Same stimulus. Required: both counters read 0.
